hop_frame_rx: RTL and testbench



---
 rtl/hop_frame_rx.sv | 118 +++++++++++
 tb/tb_hop_frame_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hop_frame_rx.sv
// hop_frame_rx: UART 8N1 receiver assembling BYTES bytes into an N*SIZE-bit pattern.
// Define HOP_RX_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module hop_frame_rx #(
  parameter int SIZE         = 8,
  parameter int N            = 8,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [N*SIZE-1:0] data,
  output logic              done,
  output logic              err
);
  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int BYTES  = (N * SIZE + 7) / 8;
  localparam int TO_MAX = TIMEOUT_BITS * DIV;
  localparam int CW     = $clog2(DIV + 1);
  localparam int IW     = $clog2(BYTES + 2);
  localparam int TW     = $clog2(TO_MAX + 1);
`ifdef HOP_RX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n, nxt_stop;
  logic [1:0]         rx_q;
  logic               rx_s, rx_d, fall, tick, fin;
  logic [CW-1:0]      cnt;
  logic [2:0]         bitn;
  logic [7:0]         sh;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      to;
  logic [BYTES*8-1:0] shadow;
  assign rx_s = rx_q[1];
  assign fall = rx_d & ~rx_s;
  assign tick = cnt == '0;
`ifdef HOP_RX_CHECKSUM_EN
  logic [7:0] xr;
  assign nxt_stop = (idx == IW'(BYTES)) ? CHK : STOP;
`else
  assign nxt_stop = STOP;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = !tick ? START : rx_s ? IDLE : DATA;
      DATA:    state_n = (tick && bitn == 3'd7) ? nxt_stop : DATA;
      default: state_n = tick ? IDLE : state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_q   <= 2'b11;
      rx_d   <= 1'b1;
      cnt    <= '0;
      bitn   <= '0;
      sh     <= '0;
      idx    <= '0;
      to     <= '0;
      shadow <= '0;
      fin    <= 1'b0;
      data   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef HOP_RX_CHECKSUM_EN
      xr     <= '0;
`endif
    end else begin
      rx_q <= {rx_q[0], rx};
      rx_d <= rx_s;
      fin  <= 1'b0;
      err  <= 1'b0;
      done <= fin;
      if (fin) data <= shadow[N*SIZE-1:0];
      cnt <= (state == IDLE) ? CW'(DIV / 2) : tick ? CW'(DIV - 1) : cnt - CW'(1);
      if (state == START) bitn <= '0;
      else if (state == DATA && tick) begin
        bitn <= bitn + 3'd1;
        sh   <= {rx_s, sh[7:1]};
      end
      // partial frame ages only while the line sits idle between bytes
      to <= (state == IDLE && idx != '0) ? to + TW'(1) : '0;
      if (state == IDLE && idx != '0 && to == TW'(TO_MAX - 1)) begin
        err <= 1'b1;
        idx <= '0;
      end
`ifdef HOP_RX_CHECKSUM_EN
      if (state == IDLE && idx == '0) xr <= '0;
      if (state == CHK && tick) begin
        idx <= '0;
        if (rx_s && sh == xr) fin <= 1'b1;
        else err <= 1'b1;
      end
`endif
      if (state == STOP && tick) begin
        if (!rx_s) begin
          err <= 1'b1;
          idx <= '0;
        end else begin
          shadow[8*int'(idx) +: 8] <= sh;
`ifdef HOP_RX_CHECKSUM_EN
          xr  <= xr ^ sh;
          idx <= idx + IW'(1);
`else
          fin <= idx == IW'(BYTES - 1);
          idx <= (idx == IW'(BYTES - 1)) ? '0 : idx + IW'(1);
`endif
        end
      end
    end
endmodule

// File: tb/tb_hop_frame_rx.sv
// tb_hop_frame_rx: randomized UART frame stimulus with a queue scoreboard for hop_frame_rx.
module tb_hop_frame_rx;
  localparam int SIZE = 8, N = 8, CLK_FREQ = 1_000_000, BAUD = 100_000;
  localparam int DIV = CLK_FREQ / BAUD, BYTES = (N * SIZE + 7) / 8, W = N * SIZE;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [W-1:0] data;
  logic done, err;
  typedef struct {bit is_err; logic [W-1:0] d;} ev_t;
  ev_t q[$];
  ev_t e;
  int checks = 0, errors = 0;
  logic [W-1:0] last_d = '0;
  typedef logic [7:0] frame_t [BYTES];
  frame_t f;

  hop_frame_rx #(.SIZE(SIZE), .N(N), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .done(done), .err(err));

  always #5 clk = ~clk;

  function automatic void check(bit ok, string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic send_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * DIV) @(negedge clk);
  endtask

  // Expected pattern: byte k occupies bits [8k+7:8k], truncated to W bits.
  task automatic send_frame(input frame_t b, input int gap, input bit bad_chk);
    logic [7:0] x = '0;
    logic [W-1:0] p = '0;
    for (int k = 0; k < BYTES; k++) begin
      x ^= b[k];
      p |= W'(b[k]) << (8 * k);
    end
`ifdef HOP_RX_CHECKSUM_EN
    if (bad_chk) q.push_back('{1'b1, last_d});
    else begin
      q.push_back('{1'b0, p});
      last_d = p;
    end
`else
    q.push_back('{1'b0, p});
    last_d = p;
`endif
    for (int k = 0; k < BYTES; k++) begin
      send_byte(b[k], 1'b1);
      if (gap > 0) idle(gap);
    end
`ifdef HOP_RX_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, 1'b1);
`endif
  endtask

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < BYTES; k++) f[k] = v;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && (done || err)) begin
      check(!(done && err), "done_err_overlap", {done, err}, 2'b00);
      check(q.size() != 0, "unexpected_event", {done, err}, 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        check(err == e.is_err, "event_kind", err, e.is_err);
        check(data == e.d, e.is_err ? "data_after_err" : "data_on_done", data, e.d);
      end
    end
  end

  initial begin
    int c;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(data == '0, "reset_data", data, 0);
    check(done == 1'b0, "reset_done", done, 0);
    check(err == 1'b0, "reset_err", err, 0);
    idle(200);
    check(data == '0, "idle_data", data, 0);

    for (int k = 0; k < BYTES; k++) f[k] = 8'(k + 1);
    send_frame(f, 0, 1'b0);
    idle(3);
    check(data == 64'h0807060504030201, "seq_frame", data, 64'h0807060504030201);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(3);
    fill(8'hAA);
    send_frame(f, 0, 1'b0);
    idle(3);

    q.push_back('{1'b1, last_d});
    for (int k = 0; k < 3; k++) send_byte(8'h33, 1'b1);
    c = 0;
    while (!err && c < 600) begin
      @(negedge clk);
      c++;
    end
    check(c >= 305 && c <= 335, "timeout_latency", c, 320);
    idle(5);
    fill(8'h11);
    send_frame(f, 0, 1'b0);
    idle(3);

    q.push_back('{1'b1, last_d});
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    idle(3);
    check(data == last_d, "data_held_after_framing", data, last_d);
    fill(8'h5A);
    send_frame(f, 0, 1'b0);
    idle(3);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < BYTES; k++) f[k] = 8'($urandom);
      send_frame(f, (r == 4) ? 30 : int'($urandom_range(0, 3)), 1'b0);
      idle($urandom_range(0, 4));
    end

`ifdef HOP_RX_CHECKSUM_EN
    for (int k = 0; k < BYTES; k++) f[k] = 8'(k + 1);
    send_frame(f, 0, 1'b0);
    idle(3);
    for (int k = 0; k < BYTES; k++) f[k] = 8'($urandom);
    send_frame(f, 0, 1'b1);
    idle(3);
`endif

    c = 0;
    while (q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check(q.size() == 0, "pending_events", q.size(), 0);

    q.push_back('{1'b0, last_d});
    send_byte(8'hC3, 1'b1);
    send_byte(8'h3C, 1'b1);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check(data == '0, "midframe_reset_data", data, 0);
    rst_n = 1'b1;
    idle(400);
    check(data == '0, "post_reset_idle_data", data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
